hazard_unit_mc: RTL and testbench

- Next-generation hazard unit for the 5-stage MIPS pipeline.
- Parametrised in register-address width and multi-cycle latency; adds a multi-cycle execute unit (mult/div) scoreboard with a structural/RAW stall state machine and a saturating stall-cycle counter.
- Sits beside the datapath and control unit: consumes D/E/M/W register fields, drives stall/flush/forward selects.

---
 rtl/hazard_unit_mc_pkg.sv | 23 ++
 rtl/hazard_unit_mc_scoreboard.sv | 106 ++++++++++
 rtl/hazard_unit_mc.sv | 143 ++++++++++++++
 tb/tb_hazard_unit_mc.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_mc_pkg.sv
// hazard_unit_mc_pkg: shared encodings for the hazard unit and its
// multi-cycle execute scoreboard.
package hazard_unit_mc_pkg;

    typedef logic [1:0] mc_state_t;
    typedef logic [1:0] fwd_sel_t;

    // Scoreboard FSM encoding.
    localparam mc_state_t MC_IDLE = 2'd0;
    localparam mc_state_t MC_BUSY = 2'd1;
    localparam mc_state_t MC_WB   = 2'd2;

    // Execute-stage operand select encoding.
    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;
    localparam fwd_sel_t FWD_MC = 2'b11;

    // Busy countdown width; wide enough for the full 1..255 latency range.
    localparam int MC_CNT_W = 8;
    typedef logic [MC_CNT_W-1:0] mc_count_t;

endpackage

// File: rtl/hazard_unit_mc_scoreboard.sv
// hazard_unit_mc_scoreboard: tracks the single multi-cycle (mult/div) unit.
// It holds the busy countdown, the pending destination register, and
// reports the RAW and structural hazards that unit causes in decode.
module hazard_unit_mc_scoreboard
    import hazard_unit_mc_pkg::*;
#(
    parameter int RW     = 5,
    parameter int MC_LAT = 4
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          mc_start_d_i,
    input  logic [RW-1:0] mc_dst_d_i,
    input  logic [RW-1:0] rs_d_i,
    input  logic [RW-1:0] rt_d_i,
    input  logic          stall_i,
    output logic          mc_raw_o,
    output logic          mc_struct_o,
    output logic          mc_busy_o,
    output logic          mc_wb_valid_o,
    output logic [RW-1:0] mc_wb_reg_o
);

    // Countdown reload so that WB is reached exactly MC_LAT edges after issue.
    localparam mc_count_t LAT_RELOAD = mc_count_t'(MC_LAT - 1);

    mc_state_t     state_q, state_d;
    mc_count_t     count_q, count_d;
    logic          pending_q, pending_d;
    logic [RW-1:0] wbReg_q, wbReg_d;
    logic          issue;
    logic          rsHit;
    logic          rtHit;

    // An op only launches when decode is not held for any reason.
    assign issue = mc_start_d_i & ~stall_i;

    // Register 0 is hard-wired, so a pending write to it never blocks a read.
    assign rsHit = (wbReg_q != '0) && (wbReg_q == rs_d_i);
    assign rtHit = (wbReg_q != '0) && (wbReg_q == rt_d_i);

    // Next-state logic: launch, count down while busy, then one WB cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pending_d = pending_q;
        wbReg_d   = wbReg_q;
        case (state_q)
            MC_IDLE: begin
                if (issue) begin
                    state_d   = MC_BUSY;
                    count_d   = LAT_RELOAD;
                    wbReg_d   = mc_dst_d_i;
                    pending_d = 1'b1;
                end
            end
            MC_BUSY: begin
                if (count_q == '0) begin
                    state_d = MC_WB;
                end else begin
                    count_d = count_q - mc_count_t'(1);
                end
            end
            MC_WB: begin
                if (issue) begin
                    state_d   = MC_BUSY;
                    count_d   = LAT_RELOAD;
                    wbReg_d   = mc_dst_d_i;
                    pending_d = 1'b1;
                end else begin
                    state_d   = MC_IDLE;
                    pending_d = 1'b0;
                end
            end
            default: begin
                state_d   = MC_IDLE;
                count_d   = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    // State registers; an asserted reset abandons any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MC_IDLE;
            count_q   <= '0;
            pending_q <= 1'b0;
            wbReg_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            wbReg_q   <= wbReg_d;
        end
    end

    // In WB the result is forwardable, so only the BUSY window blocks readers.
    assign mc_raw_o      = pending_q & (state_q == MC_BUSY) & (rsHit | rtHit);
    assign mc_struct_o   = mc_start_d_i & (state_q == MC_BUSY);
    assign mc_busy_o     = (state_q == MC_BUSY);
    assign mc_wb_valid_o = (state_q == MC_WB);
    assign mc_wb_reg_o   = wbReg_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard unit for the 5-stage MIPS pipeline with a
// multi-cycle execute unit. Produces stall/flush controls, decode and
// execute forwarding selects, and a saturating stalled-cycle counter.
module hazard_unit_mc
    import hazard_unit_mc_pkg::*;
#(
    parameter int RW     = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [RW-1:0]    rs_d,
    input  logic [RW-1:0]    rt_d,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic             taken_d,
    input  logic             mc_start_d,
    input  logic [RW-1:0]    mc_dst_d,
    input  logic [RW-1:0]    rs_e,
    input  logic [RW-1:0]    rt_e,
    input  logic [RW-1:0]    write_reg_e,
    input  logic             memtoreg_e,
    input  logic             regwrite_e,
    input  logic [RW-1:0]    write_reg_m,
    input  logic             memtoreg_m,
    input  logic             regwrite_m,
    input  logic [RW-1:0]    write_reg_w,
    input  logic             regwrite_w,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             flush_d,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             mc_busy,
    output logic             mc_wb_valid,
    output logic [RW-1:0]    mc_wb_reg,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             lwStall;
    logic             brStall;
    logic             mcRaw;
    logic             mcStruct;
    logic             hazard;
    logic             stall;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    // A register match that treats $zero as never matching anything.
    function automatic logic regHit(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    hazard_unit_mc_scoreboard #(
        .RW     (RW),
        .MC_LAT (MC_LAT)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .mc_start_d_i  (mc_start_d),
        .mc_dst_d_i    (mc_dst_d),
        .rs_d_i        (rs_d),
        .rt_d_i        (rt_d),
        .stall_i       (stall),
        .mc_raw_o      (mcRaw),
        .mc_struct_o   (mcStruct),
        .mc_busy_o     (mc_busy),
        .mc_wb_valid_o (mc_wb_valid),
        .mc_wb_reg_o   (mc_wb_reg)
    );

    // Load result is not ready until after M, so a dependent D instruction waits.
    assign lwStall = memtoreg_e & (regHit(rt_e, rs_d) | regHit(rt_e, rt_d));

    // Branch compare happens in D, so it waits on producers still in E, or loads in M.
    assign brStall = branch_d &
                     ((regwrite_e & (regHit(write_reg_e, rs_d) | regHit(write_reg_e, rt_d))) |
                      (memtoreg_m & (regHit(write_reg_m, rs_d) | regHit(write_reg_m, rt_d))));

    assign hazard = lwStall | brStall | mcRaw | mcStruct;

    // Every control output is forced low while reset is held.
    assign stall   = reset & hazard;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;
    assign flush_d = reset & ~hazard & (jump_d | (branch_d & taken_d));

    assign forward_ad = reset & regwrite_m & regHit(write_reg_m, rs_d);
    assign forward_bd = reset & regwrite_m & regHit(write_reg_m, rt_d);

    // Operand A select: the youngest producer wins (M, then MC result, then W).
    always_comb begin
        forward_ae = FWD_RF;
        if (!reset) begin
            forward_ae = FWD_RF;
        end else if (regwrite_m && regHit(write_reg_m, rs_e)) begin
            forward_ae = FWD_M;
        end else if (mc_wb_valid && regHit(mc_wb_reg, rs_e)) begin
            forward_ae = FWD_MC;
        end else if (regwrite_w && regHit(write_reg_w, rs_e)) begin
            forward_ae = FWD_W;
        end
    end

    // Operand B select, same priority as operand A.
    always_comb begin
        forward_be = FWD_RF;
        if (!reset) begin
            forward_be = FWD_RF;
        end else if (regwrite_m && regHit(write_reg_m, rt_e)) begin
            forward_be = FWD_M;
        end else if (mc_wb_valid && regHit(mc_wb_reg, rt_e)) begin
            forward_be = FWD_MC;
        end else if (regwrite_w && regHit(write_reg_w, rt_e)) begin
            forward_be = FWD_W;
        end
    end

    // Stall counter next value: count stalled cycles, stick at all-ones.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cycles = stallCnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed plus randomized checks of hazard_unit_mc
// against a cycle-count reference model of the multi-cycle unit.
module tb_hazard_unit_mc;

    localparam int RW      = 5;
    localparam int MC_LAT  = 4;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [RW-1:0]    rs_d, rt_d, mc_dst_d;
    logic             branch_d, jump_d, taken_d, mc_start_d;
    logic [RW-1:0]    rs_e, rt_e, write_reg_e;
    logic             memtoreg_e, regwrite_e;
    logic [RW-1:0]    write_reg_m;
    logic             memtoreg_m, regwrite_m;
    logic [RW-1:0]    write_reg_w;
    logic             regwrite_w;
    logic             stall_f, stall_d, flush_e, flush_d;
    logic             forward_ad, forward_bd;
    logic [1:0]       forward_ae, forward_be;
    logic             mc_busy, mc_wb_valid;
    logic [RW-1:0]    mc_wb_reg;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles left until the MC unit is idle (0 = idle,
    // 1 = writeback cycle, >1 = busy), last issued destination, stall tally.
    int            phase = 0;
    logic [RW-1:0] mcReg = '0;
    int            stallCnt = 0;

    logic          expStall, expFlushD, expFwdAd, expFwdBd, expBusy, expWb;
    logic [1:0]    expFwdAe, expFwdBe;
    logic [RW-1:0] expWbReg;
    int            expCnt;

    hazard_unit_mc #(
        .RW     (RW),
        .MC_LAT (MC_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .branch_d     (branch_d),
        .jump_d       (jump_d),
        .taken_d      (taken_d),
        .mc_start_d   (mc_start_d),
        .mc_dst_d     (mc_dst_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .memtoreg_e   (memtoreg_e),
        .regwrite_e   (regwrite_e),
        .write_reg_m  (write_reg_m),
        .memtoreg_m   (memtoreg_m),
        .regwrite_m   (regwrite_m),
        .write_reg_w  (write_reg_w),
        .regwrite_w   (regwrite_w),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .flush_d      (flush_d),
        .forward_ad   (forward_ad),
        .forward_bd   (forward_bd),
        .forward_ae   (forward_ae),
        .forward_be   (forward_be),
        .mc_busy      (mc_busy),
        .mc_wb_valid  (mc_wb_valid),
        .mc_wb_reg    (mc_wb_reg),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic hit(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] fwdE(input logic [RW-1:0] src, input logic wbValid);
        if (regwrite_m && hit(write_reg_m, src)) return 2'b10;
        if (wbValid && hit(mcReg, src))          return 2'b11;
        if (regwrite_w && hit(write_reg_w, src)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic computeExpected();
        logic busyM, wbM, lw, br, raw, strct, anyHaz;
        busyM  = (phase > 1);
        wbM    = (phase == 1);
        lw     = memtoreg_e && (hit(rt_e, rs_d) || hit(rt_e, rt_d));
        br     = branch_d &&
                 ((regwrite_e && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d))) ||
                  (memtoreg_m && (hit(write_reg_m, rs_d) || hit(write_reg_m, rt_d))));
        raw    = busyM && (hit(mcReg, rs_d) || hit(mcReg, rt_d));
        strct  = mc_start_d && busyM;
        anyHaz = lw || br || raw || strct;
        if (reset) begin
            expStall  = anyHaz;
            expFlushD = !anyHaz && (jump_d || (branch_d && taken_d));
            expFwdAd  = regwrite_m && hit(write_reg_m, rs_d);
            expFwdBd  = regwrite_m && hit(write_reg_m, rt_d);
            expFwdAe  = fwdE(rs_e, wbM);
            expFwdBe  = fwdE(rt_e, wbM);
            expBusy   = busyM;
            expWb     = wbM;
            expWbReg  = mcReg;
            expCnt    = stallCnt;
        end else begin
            expStall  = 1'b0;
            expFlushD = 1'b0;
            expFwdAd  = 1'b0;
            expFwdBd  = 1'b0;
            expFwdAe  = 2'b00;
            expFwdBe  = 2'b00;
            expBusy   = 1'b0;
            expWb     = 1'b0;
            expWbReg  = '0;
            expCnt    = 0;
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle after the input change, then compare every output with the model.
    task automatic checkOutput(input string tag);
        #1;
        computeExpected();
        checkVal({tag, ".stall_f"},      32'(stall_f),      32'(expStall));
        checkVal({tag, ".stall_d"},      32'(stall_d),      32'(expStall));
        checkVal({tag, ".flush_e"},      32'(flush_e),      32'(expStall));
        checkVal({tag, ".flush_d"},      32'(flush_d),      32'(expFlushD));
        checkVal({tag, ".forward_ad"},   32'(forward_ad),   32'(expFwdAd));
        checkVal({tag, ".forward_bd"},   32'(forward_bd),   32'(expFwdBd));
        checkVal({tag, ".forward_ae"},   32'(forward_ae),   32'(expFwdAe));
        checkVal({tag, ".forward_be"},   32'(forward_be),   32'(expFwdBe));
        checkVal({tag, ".mc_busy"},      32'(mc_busy),      32'(expBusy));
        checkVal({tag, ".mc_wb_valid"},  32'(mc_wb_valid),  32'(expWb));
        checkVal({tag, ".mc_wb_reg"},    32'(mc_wb_reg),    32'(expWbReg));
        checkVal({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(expCnt));
    endtask

    // Advance the model by the coming rising edge and move to the next falling edge.
    task automatic finishCycle();
        computeExpected();
        if (!reset) begin
            phase    = 0;
            mcReg    = '0;
            stallCnt = 0;
        end else begin
            if (mc_start_d && !expStall) begin
                phase = MC_LAT + 1;
                mcReg = mc_dst_d;
            end else if (phase > 0) begin
                phase--;
            end
            if (expStall && stallCnt < CNT_MAX) stallCnt++;
        end
        @(negedge clk);
    endtask

    task automatic clearInputs();
        rs_d = '0; rt_d = '0; branch_d = 0; jump_d = 0; taken_d = 0;
        mc_start_d = 0; mc_dst_d = '0;
        rs_e = '0; rt_e = '0; write_reg_e = '0; memtoreg_e = 0; regwrite_e = 0;
        write_reg_m = '0; memtoreg_m = 0; regwrite_m = 0;
        write_reg_w = '0; regwrite_w = 0;
    endtask

    // Random pipeline contents over a small register range so matches are common.
    task automatic applyStimulus();
        rs_d        = RW'($urandom_range(0, 7));
        rt_d        = RW'($urandom_range(0, 7));
        branch_d    = ($urandom_range(0, 3) == 0);
        jump_d      = ($urandom_range(0, 5) == 0);
        taken_d     = 1'($urandom);
        mc_start_d  = ($urandom_range(0, 3) == 0);
        mc_dst_d    = RW'($urandom_range(0, 7));
        rs_e        = RW'($urandom_range(0, 7));
        rt_e        = RW'($urandom_range(0, 7));
        write_reg_e = RW'($urandom_range(0, 7));
        memtoreg_e  = ($urandom_range(0, 3) == 0);
        regwrite_e  = 1'($urandom);
        write_reg_m = RW'($urandom_range(0, 7));
        memtoreg_m  = ($urandom_range(0, 3) == 0);
        regwrite_m  = 1'($urandom);
        write_reg_w = RW'($urandom_range(0, 7));
        regwrite_w  = 1'($urandom);
        reset       = ($urandom_range(0, 49) != 0);
    endtask

    initial begin
        int base;

        // Reset held with hazard-looking inputs: everything must read 0.
        clearInputs();
        reset = 1'b0;
        regwrite_m = 1; write_reg_m = 5'd8; rs_e = 5'd8; jump_d = 1;
        mc_start_d = 1; mc_dst_d = 5'd3; memtoreg_e = 1; rt_e = 5'd8; rs_d = 5'd8;
        checkOutput("reset");
        checkVal("reset.fwd_ae_const", 32'(forward_ae), 32'd0);
        checkVal("reset.stall_const", 32'(stall_f), 32'd0);
        finishCycle();

        reset = 1'b1;
        clearInputs();
        checkOutput("idle");
        finishCycle();

        // M beats W for the same register.
        regwrite_m = 1; write_reg_m = 5'd8; regwrite_w = 1; write_reg_w = 5'd8; rs_e = 5'd8;
        checkOutput("fwd_m_over_w");
        checkVal("fwd_m_over_w.const", 32'(forward_ae), 32'h2);
        finishCycle();

        write_reg_m = 5'd0; rs_e = 5'd0;
        checkOutput("fwd_zero_reg");
        checkVal("fwd_zero_reg.const", 32'(forward_ae), 32'h0);
        finishCycle();

        regwrite_m = 0; rs_e = 5'd8; rt_e = 5'd8;
        checkOutput("fwd_w_only");
        checkVal("fwd_w_only.const", 32'(forward_be), 32'h1);
        finishCycle();

        // Load-use stall for one cycle.
        clearInputs();
        memtoreg_e = 1; rt_e = 5'd5; rs_d = 5'd5;
        base = stallCnt;
        checkOutput("load_use");
        checkVal("load_use.stall_const", 32'(stall_f), 32'd1);
        finishCycle();
        clearInputs();
        checkOutput("load_use_after");
        checkVal("load_use_after.count", 32'(stall_cycles), 32'(base + 1));
        finishCycle();

        // Multi-cycle latency, RAW stall in BUSY, release and forward in WB.
        mc_start_d = 1; mc_dst_d = 5'd9;
        checkOutput("mc_issue");
        finishCycle();
        mc_start_d = 0; rs_d = 5'd9;
        for (int i = 0; i < MC_LAT; i++) begin
            checkOutput("mc_busy");
            checkVal("mc_busy.const", 32'(mc_busy), 32'd1);
            checkVal("mc_raw.const", 32'(stall_d), 32'd1);
            finishCycle();
        end
        rs_e = 5'd9;
        checkOutput("mc_wb");
        checkVal("mc_wb.valid_const", 32'(mc_wb_valid), 32'd1);
        checkVal("mc_wb.reg_const", 32'(mc_wb_reg), 32'd9);
        checkVal("mc_wb.stall_const", 32'(stall_d), 32'd0);
        checkVal("mc_wb.fwd_const", 32'(forward_ae), 32'h3);
        finishCycle();
        clearInputs();
        checkOutput("mc_idle");
        checkVal("mc_idle.busy_const", 32'(mc_busy), 32'd0);
        finishCycle();

        // Structural stall, then back-to-back issue out of WB.
        mc_start_d = 1; mc_dst_d = 5'd10;
        checkOutput("st_issue1");
        finishCycle();
        mc_dst_d = 5'd12;
        for (int i = 0; i < MC_LAT; i++) begin
            checkOutput("st_blocked");
            checkVal("st_blocked.const", 32'(stall_f), 32'd1);
            finishCycle();
        end
        checkOutput("st_wb_issue");
        checkVal("st_wb_issue.stall_const", 32'(stall_f), 32'd0);
        checkVal("st_wb_issue.reg_const", 32'(mc_wb_reg), 32'd10);
        finishCycle();
        mc_start_d = 0;
        checkOutput("st_rebusy");
        checkVal("st_rebusy.busy_const", 32'(mc_busy), 32'd1);
        checkVal("st_rebusy.reg_const", 32'(mc_wb_reg), 32'd12);
        finishCycle();
        for (int i = 0; i < MC_LAT + 1; i++) begin
            checkOutput("st_drain");
            finishCycle();
        end

        // Jump flush, and branch hazard suppressing the flush.
        clearInputs();
        jump_d = 1;
        checkOutput("jump");
        checkVal("jump.flush_const", 32'(flush_d), 32'd1);
        finishCycle();
        clearInputs();
        branch_d = 1; taken_d = 1; regwrite_e = 1; write_reg_e = 5'd3; rs_d = 5'd3;
        checkOutput("branch_hazard");
        checkVal("branch_hazard.stall_const", 32'(stall_f), 32'd1);
        checkVal("branch_hazard.flush_const", 32'(flush_d), 32'd0);
        finishCycle();
        regwrite_e = 0;
        checkOutput("branch_taken");
        finishCycle();

        // Reset mid-operation with two countdown steps left.
        clearInputs();
        mc_start_d = 1; mc_dst_d = 5'd7;
        checkOutput("rst_issue");
        finishCycle();
        mc_start_d = 0;
        checkOutput("rst_busy");
        finishCycle();
        reset = 1'b0;
        checkOutput("rst_async");
        checkVal("rst_async.busy_const", 32'(mc_busy), 32'd0);
        checkVal("rst_async.cnt_const", 32'(stall_cycles), 32'd0);
        finishCycle();
        reset = 1'b1;
        for (int i = 0; i < MC_LAT + 3; i++) begin
            checkOutput("rst_after");
            checkVal("rst_after.no_wb", 32'(mc_wb_valid), 32'd0);
            finishCycle();
        end

        // Counter saturation under a held load-use stall.
        memtoreg_e = 1; rt_e = 5'd5; rs_d = 5'd5;
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            checkOutput("saturate");
            finishCycle();
        end
        checkOutput("saturate_hold");
        checkVal("saturate_hold.const", 32'(stall_cycles), 32'(CNT_MAX));
        finishCycle();

        // Randomized traffic, including occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            checkOutput("random");
            finishCycle();
        end

        reset = 1'b1;
        clearInputs();
        checkOutput("final");
        finishCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
